// File: rtl/mult_scheduler.sv
// Two-port round-robin front end for a single shared 4x4 multiplier.
// Serialises requests, forwards latched operands and routes each result back to its owner.
module mult_scheduler #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [3:0] a0_i,
   input  logic [3:0] b0_i,
   input  logic [3:0] a1_i,
   input  logic [3:0] b1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic       done0_o,
   output logic       done1_o,
   output logic [7:0] res0_o,
   output logic [7:0] res1_o,
   output logic       mult_start_o,
   output logic [3:0] mult_a_o,
   output logic [3:0] mult_b_o,
   input  logic       mult_busy_i,
   input  logic       mult_valid_i,
   input  logic [7:0] mult_result_i,
   output logic       err_o
);

   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_n;
   logic          owner;
   logic          last_gnt;
   logic          grant_sel;
   logic          capture;
   logic          timeout;
   logic [3:0]    op_a;
   logic [3:0]    op_b;
   logic [CW-1:0] wait_cnt;

   // The multiplier's busy flag carries no information the valid strobe does not.
   logic unused_busy;
   assign unused_busy = mult_busy_i;

   // Operands are only presented while a transaction owns the multiplier.
   assign mult_a_o = (state == IDLE) ? 4'h0 : op_a;
   assign mult_b_o = (state == IDLE) ? 4'h0 : op_b;

   // Next-state and strobe decode; grants are gated by reset so every output reads 0 during it.
   always_comb begin
      state_n      = state;
      grant_sel    = 1'b0;
      gnt0_o       = 1'b0;
      gnt1_o       = 1'b0;
      mult_start_o = 1'b0;
      done0_o      = 1'b0;
      done1_o      = 1'b0;
      capture      = 1'b0;
      timeout      = 1'b0;
      case (state)
         IDLE: begin
            if (!rst_i && (req0_i || req1_i)) begin
               if (req0_i && req1_i) begin
                  grant_sel = ~last_gnt;
               end else begin
                  grant_sel = req1_i;
               end
               gnt0_o  = ~grant_sel;
               gnt1_o  = grant_sel;
               state_n = START;
            end
         end
         START: begin
            mult_start_o = 1'b1;
            state_n      = WAIT;
         end
         WAIT: begin
            if (mult_valid_i) begin
               capture = 1'b1;
               state_n = RESP;
            end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
               timeout = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            done0_o = ~owner;
            done1_o = owner;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // last_gnt resets to port 1 so that port 0 wins the first simultaneous request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         op_a     <= 4'h0;
         op_b     <= 4'h0;
         wait_cnt <= '0;
         res0_o   <= 8'h00;
         res1_o   <= 8'h00;
         err_o    <= 1'b0;
      end else begin
         state <= state_n;
         if (gnt0_o || gnt1_o) begin
            owner    <= grant_sel;
            last_gnt <= grant_sel;
            op_a     <= grant_sel ? a1_i : a0_i;
            op_b     <= grant_sel ? b1_i : b0_i;
         end
         if (state == START) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (capture) begin
            if (owner) begin
               res1_o <= mult_result_i;
            end else begin
               res0_o <= mult_result_i;
            end
         end else if (timeout) begin
            err_o <= 1'b1;
            if (owner) begin
               res1_o <= 8'hFF;
            end else begin
               res0_o <= 8'hFF;
            end
         end
      end
   end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the number of WAIT-state cycles without mult_valid_i after which the transaction aborts.
REQ-002 SHALL have port clk_i  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_i/req1_i  input  1  requester n wants a multiply; held until granted.
REQ-005 SHALL have ports a0_i/b0_i, a1_i/b1_i  input  4 each  operands of requester n, valid while reqn_i=1.
REQ-006 SHALL have ports gnt0_o/gnt1_o  output  1  one-cycle pulse; requester n's operands are latched this cycle.
REQ-007 SHALL have ports done0_o/done1_o  output  1  one-cycle pulse; resn_o holds a new result.
REQ-008 SHALL have ports res0_o/res1_o  output  8  last result returned to requester n.
REQ-009 SHALL have port mult_start_o  output  1  start strobe to the shared multiplier.
REQ-010 SHALL have ports mult_a_o/mult_b_o  output  4 each  operands to the multiplier.
REQ-011 SHALL have ports mult_busy_i, mult_valid_i  input  1 each  multiplier status.
REQ-012 SHALL have port mult_result_i  input  8  multiplier product.
REQ-013 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-015 IDLE: if any reqn_i=1, SHALL select one requester, assert its gntn_o combinationally in that cycle, latch its operands and owner ID, then go to START.
REQ-016 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the port not granted last wins; after reset port 0 has priority.
REQ-017 START: mult_start_o SHALL be 1 for exactly this one cycle, then go to WAIT.
REQ-018 mult_a_o/mult_b_o SHALL drive the latched operands, unchanged from START through RESP; they SHALL be 0 in IDLE.
REQ-019 WAIT: on the first cycle with mult_valid_i=1, SHALL capture mult_result_i into the owner's resn_o register and go to RESP.
REQ-020 WAIT SHALL count cycles (counter cleared on entry); if WAIT_MAX cycles elapse without mult_valid_i, SHALL set err_o, write 8'hFF to the owner's resn_o, and go to RESP.
REQ-021 RESP: SHALL pulse the owner's donen_o for one cycle, then go to IDLE.
REQ-022 The non-owner's resn_o and donen_o SHALL be unaffected by a transaction.
REQ-023 gnt and done SHALL never be asserted for both ports in the same cycle; requests arriving outside IDLE SHALL wait.
REQ-024 With a 4-bit multiplier taking 4 busy cycles, latency SHALL be: gnt in cycle 0, start in cycle 1, valid in cycle 6, done in cycle 7, next grant possible in cycle 8.
REQ-025 err_o SHALL remain 1 until reset; the scheduler SHALL continue serving requests after a timeout.
REQ-026 mult_busy_i SHALL NOT affect behaviour.

Reset
REQ-027 On rst_i=1, SHALL immediately enter IDLE, with all outputs 0, res0_o=res1_o=8'h00, err_o=0, WAIT counter 0, and round-robin pointer favouring port 0.
REQ-028 Reset mid-transaction SHALL abort the transaction with no done pulse; the first request after reset SHALL start a new transaction.

Verification
REQ-029 Bench SHALL cover: req0 with a=3, b=5, real multiplier attached -> gnt0 in cycle 0, start in cycle 1, done0 in cycle 7, res0_o=8'h0F, res1_o still 8'h00.
REQ-030 Bench SHALL cover: req0 and req1 asserted together after reset (a0=15,b0=15; a1=2,b1=7) -> port 0 served first with res0=8'hE1, then port 1 with res1=8'h0E, gnt1 in cycle 8.
REQ-031 Bench SHALL cover: both ports requesting continuously for 4 transactions -> grant order 0,1,0,1 with no cycle of overlap.
REQ-032 Bench SHALL cover: multiplier stub that never raises valid -> done pulse after WAIT_MAX=15 wait cycles, resn_o=8'hFF, err_o=1; a following request completes normally with err_o still 1.
REQ-033 Bench SHALL cover: rst_i asserted during WAIT -> all outputs 0 asynchronously, no done pulse; req1 afterwards completes correctly.
REQ-034 Bench SHALL cover: operands changing on a0_i/b0_i after gnt0 -> mult_a_o/mult_b_o hold the latched values until RESP.
